// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLL DRP sequencer: FSM states, error codes
// and the layout of one table entry.
package pll_drp_pkg;

    localparam int unsigned DrpAddrW = 7;
    localparam int unsigned DrpDataW = 16;

    localparam logic [1:0] ErrNone  = 2'd0;
    localparam logic [1:0] ErrDrdy  = 2'd1;
    localparam logic [1:0] ErrLock  = 2'd2;
    localparam logic [1:0] ErrCount = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StRd,
        StRdWait,
        StWr,
        StWrWait,
        StRelease,
        StLockWait
    } state_e;

    typedef struct packed {
        logic [DrpAddrW-1:0] addr;
        logic [DrpDataW-1:0] mask;
        logic [DrpDataW-1:0] data;
    } tbl_entry_t;

    localparam tbl_entry_t TblDefault = '{addr: '0, mask: '1, data: '0};

    // Keep the masked bits of the old value, take the rest from data.
    function automatic logic [DrpDataW-1:0] rmw(input logic [DrpDataW-1:0] old_val,
                                                input logic [DrpDataW-1:0] mask,
                                                input logic [DrpDataW-1:0] data);
        return (old_val & mask) | (data & ~mask);
    endfunction

endpackage

// File: rtl/pll_drp_sequencer_if.sv
// DRP port plus RST/LOCKED of the PLL, seen from the sequencer (master) and the
// PLL (slave).
interface pll_drp_if;
    import pll_drp_pkg::*;

    logic [DrpAddrW-1:0] daddr;
    logic                den;
    logic                dwe;
    logic [DrpDataW-1:0] di;
    logic [DrpDataW-1:0] drp_do;
    logic                drdy;
    logic                pll_rst;
    logic                locked;

    modport master (
        output daddr, den, dwe, di, pll_rst,
        input  drp_do, drdy, locked
    );

    modport slave (
        input  daddr, den, dwe, di, pll_rst,
        output drp_do, drdy, locked
    );

endinterface

// File: rtl/drp_cfg_table.sv
// Register file of DRP update entries: synchronous write, asynchronous read,
// asynchronous reset to addr 0 / keep-all mask / zero data.
module drp_cfg_table
    import pll_drp_pkg::*;
#(
    parameter int unsigned NumEntries = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       we_i,
    input  logic [4:0] wr_idx_i,
    input  tbl_entry_t wr_entry_i,
    input  logic [4:0] rd_idx_i,
    output tbl_entry_t rd_entry_o
);

    tbl_entry_t entries_q [NumEntries];

    // Out-of-range write indices match no entry and are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumEntries); i++) begin
                entries_q[i] <= TblDefault;
            end
        end else if (we_i) begin
            for (int i = 0; i < int'(NumEntries); i++) begin
                if (wr_idx_i == 5'(i)) begin
                    entries_q[i] <= wr_entry_i;
                end
            end
        end
    end

    always_comb begin
        rd_entry_o = TblDefault;
        for (int i = 0; i < int'(NumEntries); i++) begin
            if (rd_idx_i == 5'(i)) begin
                rd_entry_o = entries_q[i];
            end
        end
    end

endmodule

// File: rtl/pll_drp_sequencer.sv
// Runs a table of read-modify-write DRP updates with the PLL held in reset,
// then releases the PLL and waits for LOCKED.
module pll_drp_sequencer
    import pll_drp_pkg::*;
#(
    parameter int unsigned NumEntries  = 8,
    parameter int unsigned DrdyTimeout = 64,
    parameter int unsigned LockTimeout = 4096,
    parameter int unsigned RstHold     = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [5:0]          count_i,
    input  logic                tbl_we_i,
    input  logic [4:0]          tbl_idx_i,
    input  logic [DrpAddrW-1:0] tbl_addr_i,
    input  logic [DrpDataW-1:0] tbl_mask_i,
    input  logic [DrpDataW-1:0] tbl_data_i,
    pll_drp_if.master           drp,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [1:0]          err_code_o
);

    localparam int unsigned CntMax =
        (LockTimeout > DrdyTimeout) ? ((LockTimeout > RstHold) ? LockTimeout : RstHold)
                                    : ((DrdyTimeout > RstHold) ? DrdyTimeout : RstHold);
    localparam int unsigned CntW = $clog2(CntMax + 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [4:0]          idx_q, idx_d;
    logic [5:0]          count_q, count_d;
    logic [DrpDataW-1:0] di_q, di_d;
    logic                pll_rst_q, pll_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;

    tbl_entry_t wr_entry;
    tbl_entry_t cur_entry;
    logic       start_ok;
    logic       is_last;

    assign wr_entry = '{addr: tbl_addr_i, mask: tbl_mask_i, data: tbl_data_i};

    drp_cfg_table #(
        .NumEntries(NumEntries)
    ) u_table (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we_i      (tbl_we_i && !busy_q),
        .wr_idx_i  (tbl_idx_i),
        .wr_entry_i(wr_entry),
        .rd_idx_i  (idx_q),
        .rd_entry_o(cur_entry)
    );

    assign start_ok = (count_i != 6'd0) && (32'(count_i) <= NumEntries);
    assign is_last  = ({1'b0, idx_q} == (count_q - 6'd1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        count_d    = count_q;
        di_d       = di_q;
        pll_rst_d  = pll_rst_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (start_ok) begin
                        state_d    = StHold;
                        pll_rst_d  = 1'b1;
                        busy_d     = 1'b1;
                        err_code_d = ErrNone;
                        idx_d      = '0;
                        count_d    = count_i;
                        cnt_d      = '0;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ErrCount;
                    end
                end
            end
            StHold: begin
                if (cnt_q == CntW'(RstHold - 1)) begin
                    state_d = StRd;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRd: begin
                cnt_d   = CntW'(1);
                state_d = StRdWait;
            end
            StRdWait: begin
                // DRDY on the expiry cycle still counts as a response.
                if (drp.drdy) begin
                    di_d    = rmw(drp.drp_do, cur_entry.mask, cur_entry.data);
                    state_d = StWr;
                end else if (cnt_q == CntW'(DrdyTimeout - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = ErrDrdy;
                    busy_d     = 1'b0;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWr: begin
                cnt_d   = CntW'(1);
                state_d = StWrWait;
            end
            StWrWait: begin
                if (drp.drdy) begin
                    if (is_last) begin
                        pll_rst_d = 1'b0;
                        state_d   = StRelease;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = StRd;
                    end
                end else if (cnt_q == CntW'(DrdyTimeout - 1)) begin
                    // PLL stays in reset: its registers may be half-programmed.
                    err_d      = 1'b1;
                    err_code_d = ErrDrdy;
                    busy_d     = 1'b0;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRelease: begin
                cnt_d   = CntW'(1);
                state_d = StLockWait;
            end
            StLockWait: begin
                if (drp.locked) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (cnt_q == CntW'(LockTimeout - 1)) begin
                    err_d      = 1'b1;
                    err_code_d = ErrLock;
                    busy_d     = 1'b0;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            di_q       <= '0;
            pll_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            di_q       <= di_d;
            pll_rst_q  <= pll_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Table is frozen while busy, so the current entry's address is stable.
    assign drp.daddr   = busy_q ? cur_entry.addr : '0;
    assign drp.den     = (state_q == StRd) || (state_q == StWr);
    assign drp.dwe     = (state_q == StWr);
    assign drp.di      = di_q;
    assign drp.pll_rst = pll_rst_q;

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = err_code_q;

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Randomized scoreboard bench for pll_drp_sequencer with a behavioural PLL/DRP model.
module tb_pll_drp_sequencer;
    import pll_drp_pkg::*;

    localparam int unsigned NumEntries  = 8;
    localparam int unsigned DrdyTimeout = 64;
    localparam int unsigned LockTimeout = 4096;
    localparam int unsigned RstHold     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  count = '0;
    logic        tbl_we = 1'b0;
    logic [4:0]  tbl_idx = '0;
    logic [6:0]  tbl_addr = '0;
    logic [15:0] tbl_mask = '0;
    logic [15:0] tbl_data = '0;
    logic        busy, done, err;
    logic [1:0]  err_code;

    pll_drp_if drp ();

    pll_drp_sequencer #(
        .NumEntries (NumEntries),
        .DrdyTimeout(DrdyTimeout),
        .LockTimeout(LockTimeout),
        .RstHold    (RstHold)
    ) u_dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .count_i   (count),
        .tbl_we_i  (tbl_we),
        .tbl_idx_i (tbl_idx),
        .tbl_addr_i(tbl_addr),
        .tbl_mask_i(tbl_mask),
        .tbl_data_i(tbl_data),
        .drp       (drp),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .err_code_o(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        logic       is_err;
        logic [1:0] code;
        int         den_lat;
        int         start_lat;
    } out_t;

    acc_t       exp_acc[$];
    out_t       exp_out[$];
    tbl_entry_t tbl_model [NumEntries];
    logic [15:0] pll_mem [128];
    logic [15:0] ref_mem [128];

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int last_den_cyc = 0;
    int start_cyc = 0;
    bit den_prev = 1'b0;

    // PLL model knobs.
    bit drdy_dead = 1'b0;
    bit lock_dead = 1'b0;
    bit spur_en = 1'b0;
    int fixed_delay = 0;

    bit          pend = 1'b0;
    int          wcnt = 0;
    logic        p_we;
    logic [6:0]  p_addr;
    logic [15:0] p_di;
    int          lock_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Behavioural PLL: DRP register file, DRDY after a delay, LOCKED after release.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
            drp.drdy = 1'b0;
            drp.drp_do = '0;
            drp.locked = 1'b0;
        end else begin
            drp.drdy = 1'b0;
            if (pend) begin
                wcnt--;
                if (wcnt == 0) begin
                    pend = 1'b0;
                    drp.drdy = 1'b1;
                    if (p_we) pll_mem[p_addr] = p_di;
                    else drp.drp_do = pll_mem[p_addr];
                end
            end else if (!drp.den && spur_en && $urandom_range(7) == 0) begin
                drp.drdy = 1'b1;
                drp.drp_do = 16'($urandom);
            end
            if (drp.den && !drdy_dead) begin
                pend = 1'b1;
                p_we = drp.dwe;
                p_addr = drp.daddr;
                p_di = drp.di;
                wcnt = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 4));
            end
            if (drp.pll_rst) begin
                drp.locked = 1'b0;
                lock_cnt = int'($urandom_range(3, 40));
            end else if (lock_dead) begin
                drp.locked = 1'b0;
            end else if (lock_cnt > 0) begin
                lock_cnt--;
            end else begin
                drp.locked = 1'b1;
            end
        end
    end

    // Monitor: pops expected DRP accesses and outcomes as the DUT presents them.
    always @(negedge clk) begin : mon
        acc_t a;
        out_t o;
        if (rst_n) begin
            if (drp.den) begin
                check("den_gap", 32'(den_prev), 32'd0);
                check("pll_rst_during_den", 32'(drp.pll_rst), 32'd1);
                check("den_expected", 32'(exp_acc.size() != 0), 32'd1);
                if (exp_acc.size() != 0) begin
                    a = exp_acc.pop_front();
                    check("den_we", 32'(drp.dwe), 32'(a.we));
                    check("den_addr", 32'(drp.daddr), 32'(a.addr));
                    if (a.we) check("den_di", 32'(drp.di), 32'(a.data));
                end
                last_den_cyc = cyc;
            end
            den_prev = drp.den;
            if (done || err) begin
                check("outcome_expected", 32'(exp_out.size() != 0), 32'd1);
                if (exp_out.size() != 0) begin
                    o = exp_out.pop_front();
                    check("outcome_err", 32'(err), 32'(o.is_err));
                    check("outcome_done", 32'(done), 32'(!o.is_err));
                    check("err_code", 32'(err_code), 32'(o.code));
                    check("pll_rst_after", 32'(drp.pll_rst), 32'(o.code == ErrDrdy));
                    check("busy_after", 32'(busy), 32'd0);
                    check("accesses_left", 32'(exp_acc.size()), 32'd0);
                    if (o.den_lat >= 0) check("den_to_err", 32'(cyc - last_den_cyc), 32'(o.den_lat));
                    if (o.start_lat >= 0) check("start_to_err", 32'(cyc - start_cyc), 32'(o.start_lat));
                end
            end
        end else begin
            den_prev = 1'b0;
        end
    end

    task automatic model_defaults();
        for (int i = 0; i < int'(NumEntries); i++) tbl_model[i] = TblDefault;
    endtask

    task automatic tbl_write(input int idx, input logic [6:0] a, input logic [15:0] m,
                             input logic [15:0] d, input bit update);
        @(negedge clk);
        tbl_we = 1'b1;
        tbl_idx = 5'(idx);
        tbl_addr = a;
        tbl_mask = m;
        tbl_data = d;
        @(negedge clk);
        tbl_we = 1'b0;
        if (update && idx < int'(NumEntries)) tbl_model[idx] = '{addr: a, mask: m, data: d};
    endtask

    task automatic start_run(input int cnt);
        logic [6:0]  a;
        logic [15:0] nv;
        if (cnt == 0 || cnt > int'(NumEntries)) begin
            exp_out.push_back('{is_err: 1'b1, code: ErrCount, den_lat: -1, start_lat: 1});
        end else if (drdy_dead) begin
            exp_acc.push_back('{we: 1'b0, addr: tbl_model[0].addr, data: 16'h0});
            exp_out.push_back('{is_err: 1'b1, code: ErrDrdy, den_lat: int'(DrdyTimeout),
                                start_lat: -1});
        end else begin
            for (int i = 0; i < cnt; i++) begin
                a = tbl_model[i].addr;
                nv = (ref_mem[a] & tbl_model[i].mask) | (tbl_model[i].data & ~tbl_model[i].mask);
                ref_mem[a] = nv;
                exp_acc.push_back('{we: 1'b0, addr: a, data: 16'h0});
                exp_acc.push_back('{we: 1'b1, addr: a, data: nv});
            end
            exp_out.push_back('{is_err: lock_dead, code: lock_dead ? ErrLock : ErrNone,
                                den_lat: -1, start_lat: -1});
        end
        @(negedge clk);
        start = 1'b1;
        count = 6'(cnt);
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_outcome(input int budget);
        int n = 0;
        while (exp_out.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("outcome_in_time", 32'(exp_out.size()), 32'd0);
        exp_out.delete();
        exp_acc.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        for (int a = 0; a < 128; a++) pll_mem[a] = 16'($urandom);
        ref_mem = pll_mem;
        model_defaults();

        repeat (3) @(negedge clk);
        check("rst_den", 32'(drp.den), 32'd0);
        check("rst_pll_rst", 32'(drp.pll_rst), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_daddr", 32'(drp.daddr), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single entry, known values.
        pll_mem[8] = 16'h1234;
        ref_mem[8] = 16'h1234;
        tbl_write(0, 7'h08, 16'hF000, 16'h0041, 1'b1);
        start_run(1);
        wait_outcome(300);
        check("t1_pll_reg", 32'(pll_mem[8]), 32'h1041);

        // Four entries.
        tbl_write(1, 7'h09, 16'($urandom), 16'($urandom), 1'b1);
        tbl_write(2, 7'h14, 16'($urandom), 16'($urandom), 1'b1);
        tbl_write(3, 7'h15, 16'($urandom), 16'($urandom), 1'b1);
        start_run(4);
        wait_outcome(400);

        // DRDY never arrives.
        drdy_dead = 1'b1;
        start_run(2);
        wait_outcome(300);
        drdy_dead = 1'b0;

        // LOCKED never arrives.
        lock_dead = 1'b1;
        start_run(1);
        wait_outcome(int'(LockTimeout) + 300);
        lock_dead = 1'b0;

        // Invalid COUNT values.
        start_run(0);
        wait_outcome(20);
        start_run(int'(NumEntries) + 1);
        wait_outcome(20);

        // DRDY on the last cycle before expiry wins.
        fixed_delay = int'(DrdyTimeout) - 1;
        start_run(1);
        wait_outcome(400);
        fixed_delay = 0;

        // Randomized tables with spurious DRDY pulses.
        spur_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 4; w++) begin
                tbl_write(int'($urandom_range(0, 31)), 7'($urandom), 16'($urandom),
                          16'($urandom), 1'b1);
            end
            start_run(int'($urandom_range(1, NumEntries)));
            wait_outcome(600);
        end

        // START and table writes while busy are ignored.
        start_run(3);
        @(negedge clk);
        start = 1'b1;
        count = 6'd8;
        @(negedge clk);
        start = 1'b0;
        tbl_write(0, 7'($urandom), 16'h0000, 16'($urandom), 1'b0);
        tbl_write(2, 7'($urandom), 16'h0000, 16'($urandom), 1'b0);
        wait_outcome(600);
        start_run(3);
        wait_outcome(600);

        // Reset in the middle of a write access.
        start_run(2);
        n = 0;
        while (!(drp.den && drp.dwe) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("saw_write_den", 32'(drp.den && drp.dwe), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_den", 32'(drp.den), 32'd0);
        check("mid_rst_dwe", 32'(drp.dwe), 32'd0);
        check("mid_rst_pll_rst", 32'(drp.pll_rst), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_daddr", 32'(drp.daddr), 32'd0);
        check("mid_rst_di", 32'(drp.di), 32'd0);
        exp_acc.delete();
        exp_out.delete();
        repeat (2) @(negedge clk);
        ref_mem = pll_mem;
        model_defaults();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_run(int'(NumEntries));
        wait_outcome(800);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
